// File: rtl/vga_palette_pkg.sv
// rtl/vga_palette_pkg.sv - shared types, default colours and default-table helpers for vga_palette
package vga_palette_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FLASH = 2'd2
    } flash_state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb4_t;

    localparam rgb4_t DEF_CYAN   = 12'h0FB;
    localparam rgb4_t DEF_BLACK  = 12'h000;
    localparam rgb4_t DEF_ORANGE = 12'hFA4;

    function automatic rgb4_t make_rgb4(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        rgb4_t c;
        c.r = r;
        c.g = g;
        c.b = b;
        return c;
    endfunction

    // Title-screen colours; entries not listed are black.
    function automatic rgb4_t default_rgb4(input int idx);
        case (idx)
            0, 3:    return DEF_CYAN;
            2:       return DEF_ORANGE;
            default: return DEF_BLACK;
        endcase
    endfunction

    // Left-align a 4-bit default so callers can take the top CH_W bits.
    function automatic logic [15:0] widen4(input logic [3:0] v);
        return {v, 12'h000};
    endfunction

endpackage

// File: rtl/vga_palette_flash_ctrl.sv
// rtl/vga_palette_flash_ctrl.sv - frame-counted full-screen flash sequencer
module flash_ctrl
    import vga_palette_pkg::*;
#(
    parameter int RGB_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             flash_req,
    input  logic [RGB_W-1:0] flash_color,
    input  logic [7:0]       flash_frames,
    output logic             flash_on,
    output logic [RGB_W-1:0] flash_rgb,
    output logic             flash_busy
);

    flash_state_t     state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       len_q, len_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             frame_q, frame_d;
    logic             fs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            rgb_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            rgb_q   <= rgb_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        rgb_d   = rgb_q;
        frame_d = frame_start;
        fs_rise = frame_start & ~frame_q;
        case (state_q)
            IDLE: begin
                // A simultaneous frame_start is deliberately not honoured here.
                if (flash_req && (flash_frames != 8'd0)) begin
                    state_d = ARMED;
                    len_d   = flash_frames;
                    rgb_d   = flash_color;
                end
            end
            ARMED: begin
                if (fs_rise) begin
                    state_d = FLASH;
                    cnt_d   = len_q;
                end
            end
            FLASH: begin
                if (fs_rise) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign flash_on   = (state_q == FLASH);
    assign flash_busy = (state_q != IDLE);
    assign flash_rgb  = rgb_q;

endmodule

// File: rtl/vga_palette.sv
// rtl/vga_palette.sv - writable colour palette with blanking, transparency and flash override
module vga_palette
    import vga_palette_pkg::*;
#(
    parameter int IDX_W      = 4,
    parameter int CH_W       = 4,
    parameter int TRANSP_IDX = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [IDX_W-1:0]  color_idx,
    input  logic              blank,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [3*CH_W-1:0] wr_data,
    input  logic              flash_req,
    input  logic [3*CH_W-1:0] flash_color,
    input  logic [7:0]        flash_frames,
    output logic [CH_W-1:0]   VGA_R,
    output logic [CH_W-1:0]   VGA_G,
    output logic [CH_W-1:0]   VGA_B,
    output logic              transparent,
    output logic              flash_busy
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int RGB_W = 3 * CH_W;

    function automatic logic [RGB_W-1:0] default_entry(input int i);
        rgb4_t       c;
        logic [15:0] r16;
        logic [15:0] g16;
        logic [15:0] b16;
        c   = default_rgb4(i);
        r16 = widen4(c.r);
        g16 = widen4(c.g);
        b16 = widen4(c.b);
        return {r16[15 -: CH_W], g16[15 -: CH_W], b16[15 -: CH_W]};
    endfunction

    logic [RGB_W-1:0] table_q [DEPTH];
    logic [RGB_W-1:0] table_d [DEPTH];
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             transparent_q, transparent_d;
    logic             flash_on;
    logic [RGB_W-1:0] flash_rgb;

    flash_ctrl #(
        .RGB_W (RGB_W)
    ) u_flash_ctrl (
        .clk          (Clk),
        .rst_n        (Reset_n),
        .frame_start  (frame_start),
        .flash_req    (flash_req),
        .flash_color  (flash_color),
        .flash_frames (flash_frames),
        .flash_on     (flash_on),
        .flash_rgb    (flash_rgb),
        .flash_busy   (flash_busy)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= default_entry(i);
            end
            rgb_q         <= '0;
            transparent_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= table_d[i];
            end
            rgb_q         <= rgb_d;
            transparent_q <= transparent_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            table_d[i] = table_q[i];
        end
        if (wr_en) begin
            table_d[wr_addr] = wr_data;
        end
    end

    // Same-address write forwards the new data so the pixel never shows a stale entry.
    always_comb begin
        rgb_d = table_q[color_idx];
        if (wr_en && (wr_addr == color_idx)) begin
            rgb_d = wr_data;
        end
        if (flash_on) begin
            rgb_d = flash_rgb;
        end
        if (blank) begin
            rgb_d = '0;
        end
        transparent_d = (color_idx == IDX_W'(TRANSP_IDX)) && !flash_on;
    end

    assign VGA_R       = rgb_q[3*CH_W-1 -: CH_W];
    assign VGA_G       = rgb_q[2*CH_W-1 -: CH_W];
    assign VGA_B       = rgb_q[CH_W-1 -: CH_W];
    assign transparent = transparent_q;

endmodule

// File: tb/tb_vga_palette.sv
// tb/tb_vga_palette.sv - self-checking bench for vga_palette
module tb_vga_palette;

    logic        Clk;
    logic        Reset_n;
    logic [3:0]  color_idx;
    logic        blank;
    logic        frame_start;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic        flash_req;
    logic [11:0] flash_color;
    logic [7:0]  flash_frames;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        transparent;
    logic        flash_busy;

    int n_checks;
    int n_errors;

    vga_palette #(
        .IDX_W      (4),
        .CH_W       (4),
        .TRANSP_IDX (0)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .color_idx    (color_idx),
        .blank        (blank),
        .frame_start  (frame_start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .flash_req    (flash_req),
        .flash_color  (flash_color),
        .flash_frames (flash_frames),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
        .VGA_B        (VGA_B),
        .transparent  (transparent),
        .flash_busy   (flash_busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: palette as a plain array, flash as "frames left to show".
    logic [11:0] m_tab [16];
    bit          m_pend;
    int          m_plen;
    int          m_left;
    logic [11:0] m_pcol;
    bit          m_prev_fs;

    typedef struct {
        bit          blank;
        logic [3:0]  idx;
        bit          we;
        logic [3:0]  wa;
        logic [11:0] wd;
        logic [11:0] rgb;
        bit          tr;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [11:0] dut_rgb();
        return {VGA_R, VGA_G, VGA_B};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tab[i] = 12'h000;
        m_tab[0]  = 12'h0FB;
        m_tab[2]  = 12'hFA4;
        m_tab[3]  = 12'h0FB;
        m_pend    = 0;
        m_plen    = 0;
        m_left    = 0;
        m_pcol    = '0;
        m_prev_fs = 0;
    endtask

    task automatic idle_inputs();
        color_idx    = '0;
        blank        = 1'b0;
        frame_start  = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        flash_req    = 1'b0;
        flash_color  = '0;
        flash_frames = '0;
    endtask

    task automatic step(input string name);
        bit          active;
        bit          rise;
        logic [11:0] e_rgb;
        bit          e_tr;
        bit          e_busy;
        active = (m_left > 0);
        if (blank)                                  e_rgb = 12'h000;
        else if (active)                            e_rgb = m_pcol;
        else if (wr_en && (wr_addr == color_idx))   e_rgb = wr_data;
        else                                        e_rgb = m_tab[color_idx];
        e_tr = (color_idx == 4'd0) && !active;
        rise = frame_start && !m_prev_fs;
        m_prev_fs = frame_start;
        if (active) begin
            if (rise) m_left--;
        end else if (m_pend) begin
            if (rise) begin
                m_left = m_plen;
                m_pend = 0;
            end
        end else if (flash_req && (flash_frames != 0)) begin
            m_pend = 1;
            m_plen = int'(flash_frames);
            m_pcol = flash_color;
        end
        if (wr_en) m_tab[wr_addr] = wr_data;
        e_busy = m_pend || (m_left > 0);
        @(posedge Clk);
        #1;
        chk({name, "_rgb"},  32'(dut_rgb()),   32'(e_rgb));
        chk({name, "_tr"},   32'(transparent), 32'(e_tr));
        chk({name, "_busy"}, 32'(flash_busy),  32'(e_busy));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        model_reset();
        Reset_n = 1'b0;
        #1;
        chk("reset_rgb",  32'(dut_rgb()),   32'h000);
        chk("reset_tr",   32'(transparent), 32'h0);
        chk("reset_busy", 32'(flash_busy),  32'h0);
        #20;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        vecs[0] = '{0, 4'd0,  0, 4'd0, 12'h000, 12'h0FB, 1};
        vecs[1] = '{0, 4'd1,  0, 4'd0, 12'h000, 12'h000, 0};
        vecs[2] = '{0, 4'd2,  0, 4'd0, 12'h000, 12'hFA4, 0};
        vecs[3] = '{0, 4'd3,  0, 4'd0, 12'h000, 12'h0FB, 0};
        vecs[4] = '{0, 4'd15, 0, 4'd0, 12'h000, 12'h000, 0};
        vecs[5] = '{1, 4'd2,  0, 4'd0, 12'h000, 12'h000, 0};
        vecs[6] = '{0, 4'd3,  1, 4'd5, 12'h123, 12'h0FB, 0};
        vecs[7] = '{0, 4'd5,  0, 4'd0, 12'h000, 12'h123, 0};
        vecs[8] = '{0, 4'd7,  1, 4'd7, 12'hABC, 12'hABC, 0};
        vecs[9] = '{1, 4'd0,  0, 4'd0, 12'h000, 12'h000, 1};

        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            blank     = vecs[i].blank;
            color_idx = vecs[i].idx;
            wr_en     = vecs[i].we;
            wr_addr   = vecs[i].wa;
            wr_data   = vecs[i].wd;
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_rgb_const", i), 32'(dut_rgb()),   32'(vecs[i].rgb));
            chk($sformatf("vec%0d_tr_const", i),  32'(transparent), 32'(vecs[i].tr));
        end

        // Flash of 2 frames in white, with an ignored retrigger and a blank inside it.
        idle_inputs();
        color_idx    = 4'd2;
        flash_req    = 1'b1;
        flash_frames = 8'd2;
        flash_color  = 12'hFFF;
        step("fl_req");
        chk("fl_req_busy", 32'(flash_busy), 32'h1);
        chk("fl_req_rgb",  32'(dut_rgb()),  32'hFA4);
        idle_inputs();
        color_idx = 4'd2;
        step("fl_armed");
        chk("fl_armed_rgb", 32'(dut_rgb()), 32'hFA4);
        frame_start = 1'b1;
        step("fl_fs1");
        frame_start = 1'b0;
        color_idx   = 4'd0;
        step("fl_on");
        chk("fl_on_rgb", 32'(dut_rgb()),   32'hFFF);
        chk("fl_on_tr",  32'(transparent), 32'h0);
        flash_req    = 1'b1;
        flash_frames = 8'd5;
        flash_color  = 12'h123;
        step("fl_retrig");
        chk("fl_retrig_rgb", 32'(dut_rgb()), 32'hFFF);
        idle_inputs();
        blank     = 1'b1;
        color_idx = 4'd2;
        step("fl_blank");
        chk("fl_blank_rgb", 32'(dut_rgb()), 32'h000);
        idle_inputs();
        frame_start = 1'b1;
        step("fl_fs2");
        frame_start = 1'b0;
        step("fl_frame2");
        chk("fl_frame2_rgb", 32'(dut_rgb()), 32'hFFF);
        frame_start = 1'b1;
        step("fl_fs3");
        chk("fl_fs3_busy", 32'(flash_busy), 32'h0);
        frame_start = 1'b0;
        step("fl_done");
        chk("fl_done_rgb", 32'(dut_rgb()),   32'h0FB);
        chk("fl_done_tr",  32'(transparent), 32'h1);

        // Zero-length request, and request coinciding with frame_start.
        flash_req    = 1'b1;
        flash_frames = 8'd0;
        flash_color  = 12'h555;
        step("fl_zero");
        chk("fl_zero_busy", 32'(flash_busy), 32'h0);
        idle_inputs();
        step("gap");
        flash_req    = 1'b1;
        flash_frames = 8'd1;
        flash_color  = 12'h9C3;
        frame_start  = 1'b1;
        step("fl_coinc");
        idle_inputs();
        color_idx = 4'd1;
        step("fl_coinc_wait");
        chk("fl_coinc_armed_rgb", 32'(dut_rgb()), 32'h000);
        frame_start = 1'b1;
        step("fl_coinc_fs");
        frame_start = 1'b0;
        step("fl_coinc_on");
        chk("fl_coinc_on_rgb", 32'(dut_rgb()), 32'h9C3);
        frame_start = 1'b1;
        step("fl_coinc_end");
        idle_inputs();
        step("fl_coinc_idle");

        // Async reset in the middle of a flash, after rewriting entry 2.
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 12'h777;
        step("rst_wr");
        idle_inputs();
        flash_req    = 1'b1;
        flash_frames = 8'd3;
        flash_color  = 12'hE0E;
        step("rst_req");
        idle_inputs();
        frame_start = 1'b1;
        step("rst_fs");
        frame_start = 1'b0;
        color_idx   = 4'd2;
        step("rst_on");
        chk("rst_on_rgb", 32'(dut_rgb()), 32'hE0E);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_async_rgb",  32'(dut_rgb()),   32'h000);
        chk("rst_async_busy", 32'(flash_busy),  32'h0);
        chk("rst_async_tr",   32'(transparent), 32'h0);
        model_reset();
        idle_inputs();
        @(negedge Clk);
        #2;
        Reset_n   = 1'b1;
        color_idx = 4'd2;
        step("rst_after");
        chk("rst_after_rgb", 32'(dut_rgb()), 32'hFA4);

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            blank        = ($urandom_range(7) == 0);
            color_idx    = 4'($urandom);
            wr_en        = ($urandom_range(5) == 0);
            wr_addr      = ($urandom_range(3) == 0) ? color_idx : 4'($urandom);
            wr_data      = 12'($urandom);
            frame_start  = ($urandom_range(14) == 0);
            flash_req    = ($urandom_range(24) == 0);
            flash_frames = 8'($urandom_range(3));
            flash_color  = 12'($urandom);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
